// File: rtl/instr_decode_buffer.sv
// instr_decode_buffer: decode-stage front end. It accepts 16-bit instruction
// words from fetch over valid/ready, decodes them on push, and holds up to
// two decoded entries in a skid FIFO. The head entry drives the outputs.
// Supports a synchronous flush on a taken branch or jump.
// Optional feature: define INSTR_DECODE_COUNT_EN to add the issue_count port,
// a 16-bit counter of popped instructions.
module instr_decode_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [15:0] instr_data,
   output logic        instr_ready,
   input  logic        flush,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [7:0]  instructionOp,
   output logic [7:0]  immediate,
   output logic [3:0]  rdest,
   output logic [3:0]  rsrc,
`ifdef INSTR_DECODE_COUNT_EN
   output logic [15:0] issue_count,
`endif
   output logic        illegal
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   // Op/ext code: register ALU, load/store/jump and shift classes keep the
   // secondary opcode nibble; every other class zeroes it.
   function automatic logic [7:0] decode_op(input logic [15:0] word);
      logic [7:0] op;
      case (word[15:12])
         4'h0, 4'h4, 4'h8: op = {word[15:12], word[7:4]};
         default:          op = {word[15:12], 4'h0};
      endcase
      return op;
   endfunction

   // Opcodes 0110 and 0111 are reserved.
   function automatic logic decode_illegal(input logic [15:0] word);
      return (word[15:12] == 4'h6) || (word[15:12] == 4'h7);
   endfunction

   logic       head;
   logic       tail;
   logic [1:0] count;
   logic       rdy_en;
   logic       push;
   logic       pop;

   logic [7:0] op_p0   [DEPTH];
   logic [7:0] imm_p0  [DEPTH];
   logic [3:0] rdest_p0[DEPTH];
   logic [3:0] rsrc_p0 [DEPTH];
   logic       ill_p0  [DEPTH];

   // Ready comes only from registered state, so it never depends on instr_valid.
   assign instr_ready = rdy_en && (count != FULL);
   assign dec_valid   = (count != 2'd0);
   assign push        = instr_valid && instr_ready && !flush;
   assign pop         = dec_valid && dec_ready && !flush;

   // Outputs come straight from the head entry register.
   assign instructionOp = op_p0[head];
   assign immediate     = imm_p0[head];
   assign rdest         = rdest_p0[head];
   assign rsrc          = rsrc_p0[head];
   assign illegal       = ill_p0[head];

   // FIFO control: pointers, occupancy, and the post-reset ready enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
         end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // Decode on push into the tail entry; reset clears entries so the outputs read zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            op_p0[i]    <= 8'h00;
            imm_p0[i]   <= 8'h00;
            rdest_p0[i] <= 4'h0;
            rsrc_p0[i]  <= 4'h0;
            ill_p0[i]   <= 1'b0;
         end
      end else if (push) begin
         op_p0[tail]    <= decode_op(instr_data);
         imm_p0[tail]   <= instr_data[7:0];
         rdest_p0[tail] <= instr_data[11:8];
         rsrc_p0[tail]  <= instr_data[3:0];
         ill_p0[tail]   <= decode_illegal(instr_data);
      end
   end

`ifdef INSTR_DECODE_COUNT_EN
   // Issue counter: counts pops, wraps naturally, survives flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    issue_count <= 16'h0000;
      else if (pop) issue_count <= issue_count + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Bench for instr_decode_buffer: directed stimulus, a queue-based reference
// model checked every negedge, plus literal expectations at key points.
module tb_instr_decode_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr_data;
   logic        instr_ready;
   logic        flush;
   logic        dec_valid;
   logic        dec_ready;
   logic [7:0]  instructionOp;
   logic [7:0]  immediate;
   logic [3:0]  rdest;
   logic [3:0]  rsrc;
   logic        illegal;
`ifdef INSTR_DECODE_COUNT_EN
   logic [15:0] issue_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   instr_decode_buffer #(.DEPTH(2)) dut (
      .clk(clk),
      .reset(reset),
      .instr_valid(instr_valid),
      .instr_data(instr_data),
      .instr_ready(instr_ready),
      .flush(flush),
      .dec_valid(dec_valid),
      .dec_ready(dec_ready),
      .instructionOp(instructionOp),
      .immediate(immediate),
      .rdest(rdest),
      .rsrc(rsrc),
`ifdef INSTR_DECODE_COUNT_EN
      .issue_count(issue_count),
`endif
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of raw words; fields derived from the word.
   logic [15:0] mq[$];
   logic        m_rdy;
   logic [15:0] m_issue;

   function automatic logic [7:0] ref_op(input logic [15:0] w);
      if (w[15:12] == 4'h0 || w[15:12] == 4'h4 || w[15:12] == 4'h8)
         return {w[15:12], w[7:4]};
      return {w[15:12], 4'h0};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_rdy   = 1'b0;
         m_issue = 16'h0;
      end else begin
         if (!flush) begin
            logic do_push;
            do_push = instr_valid && m_rdy && (mq.size() < 2);
            if (mq.size() > 0 && dec_ready) begin
               void'(mq.pop_front());
               m_issue = m_issue + 16'h1;
            end
            if (do_push) mq.push_back(instr_data);
         end else begin
            mq.delete();
         end
         m_rdy = 1'b1;
      end
   end

   // Compare process: every negedge, DUT against the model.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
         chk("rst_instr_ready", {31'b0, instr_ready}, 32'd0);
         chk("rst_op", {24'b0, instructionOp}, 32'd0);
         chk("rst_imm", {24'b0, immediate}, 32'd0);
      end else begin
         chk("m_dec_valid", {31'b0, dec_valid}, {31'b0, mq.size() != 0});
         chk("m_instr_ready", {31'b0, instr_ready}, {31'b0, m_rdy && (mq.size() < 2)});
         if (mq.size() != 0) begin
            chk("m_op", {24'b0, instructionOp}, {24'b0, ref_op(mq[0])});
            chk("m_imm", {24'b0, immediate}, {24'b0, mq[0][7:0]});
            chk("m_rdest", {28'b0, rdest}, {28'b0, mq[0][11:8]});
            chk("m_rsrc", {28'b0, rsrc}, {28'b0, mq[0][3:0]});
            chk("m_illegal", {31'b0, illegal}, {31'b0, (mq[0][15:13] == 3'b011)});
         end
`ifdef INSTR_DECODE_COUNT_EN
         chk("m_issue_count", {16'b0, issue_count}, {16'b0, m_issue});
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr_data = 16'h0; flush = 1'b0; dec_ready = 1'b0;
      step(); step();
      chk("reset_dec_valid", {31'b0, dec_valid}, 32'd0);
      chk("reset_ready_held", {31'b0, instr_ready}, 32'd0);
      reset = 1'b0;
      step();
      chk("ready_after_reset", {31'b0, instr_ready}, 32'd1);

      // Single ADDI word.
      dec_ready = 1'b1;
      instr_valid = 1'b1; instr_data = 16'h5A12;
      step();
      instr_valid = 1'b0;
      chk("addi_valid", {31'b0, dec_valid}, 32'd1);
      chk("addi_op", {24'b0, instructionOp}, 32'h50);
      chk("addi_imm", {24'b0, immediate}, 32'h12);
      chk("addi_rdest", {28'b0, rdest}, 32'hA);
      chk("addi_rsrc", {28'b0, rsrc}, 32'h2);
      chk("addi_illegal", {31'b0, illegal}, 32'd0);
      step();
      chk("addi_drained", {31'b0, dec_valid}, 32'd0);

      // Back-to-back shift/ALU words, no bubbles.
      instr_valid = 1'b1; instr_data = 16'h8314;
      step();
      chk("lshi1_op", {24'b0, instructionOp}, 32'h81);
      chk("lshi1_imm", {24'b0, immediate}, 32'h14);
      instr_data = 16'h8301;
      step();
      chk("lshi0_op", {24'b0, instructionOp}, 32'h80);
      chk("lshi0_imm", {24'b0, immediate}, 32'h01);
      instr_data = 16'h0352;
      step();
      instr_valid = 1'b0;
      chk("alu_op", {24'b0, instructionOp}, 32'h05);
      chk("alu_rdest", {28'b0, rdest}, 32'h3);
      chk("alu_rsrc", {28'b0, rsrc}, 32'h2);
      step();

      // Backpressure: fill to two, third word held by fetch.
      dec_ready = 1'b0;
      instr_valid = 1'b1; instr_data = 16'hC4F0;
      step();
      instr_data = 16'h9105;
      step();
      chk("full_ready_low", {31'b0, instr_ready}, 32'd0);
      instr_data = 16'hB2FF;
      step(); step(); step();
      chk("hold_op", {24'b0, instructionOp}, 32'hC0);
      chk("hold_imm", {24'b0, immediate}, 32'hF0);
      dec_ready = 1'b1;
      step();
      chk("subi_op", {24'b0, instructionOp}, 32'h90);
      chk("subi_imm", {24'b0, immediate}, 32'h05);
      step();
      instr_valid = 1'b0;
      chk("cmpi_op", {24'b0, instructionOp}, 32'hB0);
      chk("cmpi_imm", {24'b0, immediate}, 32'hFF);
      step();

      // Flush while full, with a word presented alongside.
      dec_ready = 1'b0;
      instr_valid = 1'b1; instr_data = 16'h2345;
      step();
      instr_data = 16'h3456;
      step();
      instr_data = 16'h1234; flush = 1'b1;
      step();
      flush = 1'b0; instr_valid = 1'b0;
      chk("flush_dec_valid", {31'b0, dec_valid}, 32'd0);
      chk("flush_ready", {31'b0, instr_ready}, 32'd1);
      // Flush while empty and ready: word still dropped.
      instr_valid = 1'b1; instr_data = 16'h1234; flush = 1'b1;
      step();
      flush = 1'b0; instr_valid = 1'b0;
      step();
      chk("flush_drop", {31'b0, dec_valid}, 32'd0);

      // Reserved opcodes delivered with illegal set.
      instr_valid = 1'b1; instr_data = 16'h6000;
      step();
      instr_data = 16'h7ABC;
      step();
      instr_valid = 1'b0;
      chk("ill6_flag", {31'b0, illegal}, 32'd1);
      chk("ill6_op", {24'b0, instructionOp}, 32'h60);
      dec_ready = 1'b1;
      step();
      chk("ill7_flag", {31'b0, illegal}, 32'd1);
      chk("ill7_op", {24'b0, instructionOp}, 32'h70);
      step();
      chk("ill_drained", {31'b0, dec_valid}, 32'd0);

      // Asynchronous reset with the buffer full.
      dec_ready = 1'b0;
      instr_valid = 1'b1; instr_data = 16'h4F37;
      step();
      instr_data = 16'h0EA9;
      step();
      instr_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_dec_valid", {31'b0, dec_valid}, 32'd0);
      chk("async_op", {24'b0, instructionOp}, 32'd0);
      chk("async_rdest", {28'b0, rdest}, 32'd0);
      chk("async_ready", {31'b0, instr_ready}, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("post_reset_ready", {31'b0, instr_ready}, 32'd1);

`ifdef INSTR_DECODE_COUNT_EN
      dec_ready = 1'b1;
      instr_valid = 1'b1; instr_data = 16'h0123;
      step(); step(); step();
      instr_valid = 1'b0;
      step();
      chk("issue_count_3", {16'b0, issue_count}, 32'd3);
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
